// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC arbitration, post-redirect flush window and EPC for a single-level interrupt handler
module pc_sequencer #(
   parameter logic [15:0] IRQ_VEC      = 16'h0100,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc_i,
   input  logic        stall_i,
   input  logic        br_taken_i,
   input  logic [15:0] br_target_i,
   input  logic        jmp_i,
   input  logic [15:0] jmp_target_i,
   input  logic        irq_i,
   input  logic        eret_i,
   output logic        next_pc_sel_o,
   output logic [15:0] target_pc_o,
   output logic        flush_o,
   output logic        in_handler_o,
   output logic [15:0] epc_o
);
   typedef enum logic {RUN, HANDLER} mode_e;
   localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);
   mode_e       mode_q, mode_d;
   logic [2:0]  fcnt_q, fcnt_d;
   logic [15:0] epc_q, epc_d, raw_tgt;
   logic        redir;
   // state register; reset clears mode, flush window and saved return address
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q <= RUN;
         fcnt_q <= 3'd0;
         epc_q  <= 16'h0000;
      end else begin
         mode_q <= mode_d;
         fcnt_q <= fcnt_d;
         epc_q  <= epc_d;
      end
   end
   // priority arbitration: stall, flush shadow, branch, jump, eret, irq
   always_comb begin
      mode_d        = mode_q;
      fcnt_d        = fcnt_q;
      epc_d         = epc_q;
      raw_tgt       = 16'h0000;
      redir         = 1'b0;
      next_pc_sel_o = 1'b0;
      target_pc_o   = 16'h0000;
      if (reset) begin
         redir = 1'b0;
      end else if (stall_i) begin
         next_pc_sel_o = 1'b1;
         target_pc_o   = pc_i;
      end else if (fcnt_q != 3'd0) begin
         fcnt_d = fcnt_q - 3'd1;
      end else if (br_taken_i) begin
         redir   = 1'b1;
         raw_tgt = br_target_i;
      end else if (jmp_i) begin
         redir   = 1'b1;
         raw_tgt = jmp_target_i;
      end else if (eret_i && mode_q == HANDLER) begin
         redir   = 1'b1;
         raw_tgt = epc_q;
         mode_d  = RUN;
      end else if (irq_i && mode_q == RUN) begin
         redir   = 1'b1;
         raw_tgt = IRQ_VEC;
         epc_d   = pc_i;
         mode_d  = HANDLER;
      end
      if (redir) begin
         next_pc_sel_o = 1'b1;
         target_pc_o   = {raw_tgt[15:2], 2'b00};
         fcnt_d        = FLUSH_LD;
      end
   end
   assign flush_o      = !reset && fcnt_q != 3'd0;
   assign in_handler_o = mode_q == HANDLER;
   assign epc_o        = epc_q;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 16-bit `program_counter` register. It arbitrates redirect sources each cycle: pipeline stall, taken branch, jump, interrupt entry and interrupt return. It drives the counter's `next_pc_sel`/`target_pc` inputs, generates the pipeline flush window after every redirect, and holds the exception return address (EPC) for a single-level interrupt handler.

## Interface
- IRQ_VEC, 16'h0100 — handler entry address; must be word-aligned.
- FLUSH_CYCLES, 2 — cycles `flush` stays high after a redirect; legal range 1..7.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  16  current value of `program_counter.pc`.
- stall  in  1  hold fetch; PC must not change.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  16  branch destination.
- jmp  in  1  ID-stage unconditional jump.
- jmp_target  in  16  jump destination.
- irq  in  1  level interrupt request; the source holds it until serviced.
- eret  in  1  return-from-interrupt, decoded in ID.
- next_pc_sel  out  1  to `program_counter`; 1 loads `target_pc`, 0 advances by 4.
- target_pc  out  16  redirect address.
- flush  out  1  squash younger pipeline stages.
- in_handler  out  1  high while in the interrupt handler; interrupts are masked.
- epc  out  16  saved return address.

## Operation
- Registered state:
  - mode: RUN or HANDLER.
  - flush counter `fcnt`: 3 bits.
  - `epc`: 16 bits.
- `next_pc_sel` and `target_pc` are combinational from the inputs and registered state, so a redirect takes effect at the very next edge.
- Per-cycle priority, highest first:
  1. reset: `next_pc_sel`=0, `target_pc`=0, `flush`=0; state is cleared.
  2. stall: `next_pc_sel`=1, `target_pc`=`pc`. All other requests are ignored and `fcnt` is frozen.
  3. `fcnt`≠0: `br_taken`, `jmp`, `eret` and `irq` are all ignored, because they come from squashed instructions. The PC advances by 4.
  4. br_taken: redirect to `br_target`. It wins over `jmp` because it is the older instruction.
  5. jmp: redirect to `jmp_target`.
  6. eret with mode=HANDLER: redirect to `epc`, then mode←RUN. `eret` in RUN is a no-op.
  7. irq with mode=RUN: `epc`←`pc`, redirect to IRQ_VEC, then mode←HANDLER. `irq` in HANDLER is ignored.
  8. Otherwise `next_pc_sel`=0 and the PC advances by 4.
- Every redirect in rules 4–7:
  - `target_pc[1:0]` is forced to 2'b00.
  - `fcnt` is loaded with FLUSH_CYCLES.
- With `fcnt`≠0 and no stall, `fcnt` decrements by 1 each cycle.
- `flush` = (`fcnt`≠0).
- `in_handler` = (mode==HANDLER).
- `epc` is written only by rule 7 and is otherwise held.
- Address wrap: PC wrap from 16'hFFFC to 0 is owned by `program_counter`. `epc` and redirect targets are stored modulo 2^16 with no checks.
- No nesting: `irq` is masked for the whole handler, and a second `irq` is taken only after the `eret` flush ends.

## Timing
- Reset values: mode=RUN, `fcnt`=0, `epc`=0, `flush`=0, `in_handler`=0, `next_pc_sel`=0, `target_pc`=0.
- Reset asserted mid-handler or mid-flush clears all state at the next edge. Requests pending during reset are not remembered.
- Redirect latency:
  - A request accepted in cycle N gives `pc`=target after edge N.
  - `flush` is high for cycles N+1 .. N+FLUSH_CYCLES, plus any stalled cycles inside that window.
- Interrupt latency: with `irq` first high in cycle N and nothing blocking, `epc` and `in_handler` update and `pc`=IRQ_VEC after edge N.
- When `irq` is blocked by stall, flush, branch or jump, it is taken in the first eligible cycle. The `epc` saved is `pc` in that cycle.
- Simultaneous events:
  - br_taken+irq in the same cycle: the branch is taken. `irq` is serviced after the flush, with `epc` equal to the branch target path.
  - eret+irq in HANDLER: `eret` is taken. `irq` is eligible FLUSH_CYCLES cycles after the return.

## Test plan
- Reset then 3 free cycles: `next_pc_sel`=0 throughout, `pc` goes 0→4→8→C, `flush`=0.
- At `pc`=16'h0010, assert `br_taken` with `br_target`=16'h0043 and `jmp`=1 with `jmp_target`=16'h0080 → `target_pc`=16'h0040 and `pc`=16'h0040 next cycle. `flush` is high for exactly 2 cycles, and a `jmp` pulsed during those cycles is ignored.
- Hold `stall` for 3 cycles at `pc`=16'h0020, with `br_taken` also high in the first cycle → `pc` stays 16'h0020 and the branch is ignored. Releasing `stall` gives `pc`=16'h0024.
- Raise `irq` at `pc`=16'h0030 → `epc`=16'h0030, `in_handler`=1, `pc`=16'h0100. Keep `irq` high for 10 more cycles → no re-entry and `epc` unchanged.
- Continuing the previous scenario, pulse `eret` after the flush ends → `pc`=16'h0030, `in_handler`=0. An `irq` still held is re-taken exactly 3 cycles after the return edge: 2 flush cycles, then the request cycle.
- Assert reset while in HANDLER with `fcnt`=1 → next edge gives `in_handler`=0, `flush`=0, `epc`=0, and `pc`=0.
